// File: rtl/hog_cell_hist_gen_if.sv
// rtl/hog_cell_hist_gen_if.sv - pixel-vote input and cell-histogram output bundle
interface hog_cell_hist_gen_if #(
  parameter int ADDR_W = 11,
  parameter int MAG_W  = 16,
  parameter int BIN_W  = 32
);
  logic [MAG_W-1:0]     i_mag;
  logic [3:0]           i_bin_idx;
  logic                 i_sof;
  logic                 i_valid;
  logic [ADDR_W-1:0]    addr_fw;
  logic                 valid_fw;
  logic [ADDR_W-1:0]    address;
  logic [9*BIN_W-1:0]   bin;
  logic                 o_valid;

  modport slave (
    input  i_mag, i_bin_idx, i_sof, i_valid,
    output addr_fw, valid_fw, address, bin, o_valid
  );

  modport master (
    output i_mag, i_bin_idx, i_sof, i_valid,
    input  addr_fw, valid_fw, address, bin, o_valid
  );
endinterface

// File: rtl/hog_cell_hist_gen.sv
// rtl/hog_cell_hist_gen.sv - accumulates raster pixel votes into 9-bin 8x8 cell histograms
module hog_cell_hist_gen #(
  parameter int ADDR_W    = 11,
  parameter int BIN_I     = 16,
  parameter int BIN_F     = 16,
  parameter int MAG_W     = 16,
  parameter int CELL_COLS = 40,
  parameter int CELL_ROWS = 30,
  parameter int CELL_SZ   = 8
) (
  input logic              clk,
  input logic              rst,
  hog_cell_hist_gen_if.slave px
);
  localparam int BIN_W   = BIN_I + BIN_F;
  localparam int NBINS   = 9;
  localparam int PX_COLS = CELL_COLS * CELL_SZ;
  localparam int PX_ROWS = CELL_ROWS * CELL_SZ;
  localparam int CW      = $clog2(PX_COLS);
  localparam int RW      = $clog2(PX_ROWS);
  localparam int LSZ     = $clog2(CELL_SZ);
  localparam int CCW     = CW - LSZ;
  localparam int CRW     = RW - LSZ;

  typedef enum logic {WAIT_SOF, RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [BIN_W-1:0]      acc_q [CELL_COLS][NBINS];
  logic                  done_q;
  logic [CCW-1:0]        done_col_q;
  logic [ADDR_W-1:0]     done_addr_q;
  logic                  valid_fw_q, o_valid_q;
  logic [ADDR_W-1:0]     addr_fw_q, address_q;
  logic [NBINS*BIN_W-1:0] bin_q, rd_flat;

  logic                  sof_acc, accept, last_col, last_row, cell_start, cell_end;
  logic                  vote_ok, fresh;
  logic [CW-1:0]         pos_col;
  logic [RW-1:0]         pos_row;
  logic [CCW-1:0]        cc;
  logic [CRW-1:0]        cr;
  logic [ADDR_W-1:0]     cell_addr;
  logic [BIN_W-1:0]      base, vote_sat;
  logic [BIN_W:0]        vote_sum;

  // An sof pixel is always accepted and restarts the frame at pixel (0,0).
  assign sof_acc    = px.i_valid & px.i_sof;
  assign accept     = px.i_valid & (px.i_sof | (state_q == RUN));
  assign pos_col    = sof_acc ? '0 : col_q;
  assign pos_row    = sof_acc ? '0 : row_q;
  assign last_col   = (pos_col == CW'(PX_COLS - 1));
  assign last_row   = (pos_row == RW'(PX_ROWS - 1));
  assign cc         = pos_col[CW-1:LSZ];
  assign cr         = pos_row[RW-1:LSZ];
  assign cell_start = (pos_col[LSZ-1:0] == '0) && (pos_row[LSZ-1:0] == '0);
  assign cell_end   = (pos_col[LSZ-1:0] == '1) && (pos_row[LSZ-1:0] == '1);
  assign cell_addr  = ADDR_W'(cr) * ADDR_W'(CELL_COLS) + ADDR_W'(cc);

  // A slot being read out this cycle, or a frame restart, makes the vote start from zero.
  assign vote_ok  = (px.i_bin_idx < 4'd9);
  assign fresh    = sof_acc | (done_q & (done_col_q == cc));
  assign base     = fresh ? '0 : acc_q[cc][px.i_bin_idx];
  assign vote_sum = {1'b0, base} + (BIN_W + 1)'({px.i_mag, {BIN_F{1'b0}}});
  assign vote_sat = vote_sum[BIN_W] ? '1 : vote_sum[BIN_W-1:0];

  always_comb begin
    rd_flat = '0;
    for (int b = 0; b < NBINS; b++) begin
      rd_flat[b*BIN_W +: BIN_W] = acc_q[done_col_q][b];
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      state_d = (last_col && last_row) ? WAIT_SOF : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_SOF;
      col_q       <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
      done_col_q  <= '0;
      done_addr_q <= '0;
      valid_fw_q  <= 1'b0;
      addr_fw_q   <= '0;
      o_valid_q   <= 1'b0;
      address_q   <= '0;
      bin_q       <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= accept & cell_end;
      valid_fw_q <= accept & cell_start;
      o_valid_q  <= done_q;
      if (accept && cell_end) begin
        done_col_q  <= cc;
        done_addr_q <= cell_addr;
      end
      if (accept && cell_start) addr_fw_q <= cell_addr;
      if (done_q) begin
        address_q <= done_addr_q;
        bin_q     <= rd_flat;
      end
    end
  end

  // Vote write is last so it overrides the readout/frame clears on the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CELL_COLS; c++)
        for (int b = 0; b < NBINS; b++)
          acc_q[c][b] <= '0;
    end else begin
      if (sof_acc) begin
        for (int c = 0; c < CELL_COLS; c++)
          for (int b = 0; b < NBINS; b++)
            acc_q[c][b] <= '0;
      end else if (done_q) begin
        for (int b = 0; b < NBINS; b++)
          acc_q[done_col_q][b] <= '0;
      end
      if (accept && vote_ok) acc_q[cc][px.i_bin_idx] <= vote_sat;
    end
  end

  assign px.valid_fw = valid_fw_q;
  assign px.addr_fw  = addr_fw_q;
  assign px.o_valid  = o_valid_q;
  assign px.address  = address_q;
  assign px.bin      = bin_q;
endmodule

// File: tb/tb_hog_cell_hist_gen.sv
// tb/tb_hog_cell_hist_gen.sv - directed vector bench for hog_cell_hist_gen on a 4x3-cell frame
module tb_hog_cell_hist_gen;
  localparam int CC    = 4;
  localparam int CR    = 3;
  localparam int SZ    = 8;
  localparam int W_PX  = CC * SZ;
  localparam int NPX   = CC * CR * SZ * SZ;
  localparam int NCELL = CC * CR;
  localparam int BW    = 32;
  localparam int TOT   = 9 * BW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  hog_cell_hist_gen_if #(.ADDR_W(11), .MAG_W(16), .BIN_W(BW)) px_if ();

  hog_cell_hist_gen #(
    .ADDR_W(11), .BIN_I(16), .BIN_F(16), .MAG_W(16),
    .CELL_COLS(CC), .CELL_ROWS(CR), .CELL_SZ(SZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .px (px_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int             ov_addr[$];
  logic [TOT-1:0] ov_bin[$];
  int             ov_cyc[$];
  int             fw_addr[$];
  int             fw_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      if (px_if.o_valid) begin
        ov_addr.push_back(int'(px_if.address));
        ov_bin.push_back(px_if.bin);
        ov_cyc.push_back(cyc);
      end
      if (px_if.valid_fw) begin
        fw_addr.push_back(int'(px_if.addr_fw));
        fw_cyc.push_back(cyc);
      end
    end
  end

  typedef struct {
    logic [15:0] mag;
    logic [3:0]  idx;
    bit          drop4;
    bit          gaps;
    int          exp_bin;
    logic [31:0] exp_val;
  } vec_t;

  task automatic clear_logs();
    ov_addr.delete(); ov_bin.delete(); ov_cyc.delete();
    fw_addr.delete(); fw_cyc.delete();
  endtask

  task automatic chk(input string nm, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input logic [15:0] mag, input logic [3:0] idx, input bit sof);
    px_if.i_mag     = mag;
    px_if.i_bin_idx = idx;
    px_if.i_sof     = sof;
    px_if.i_valid   = 1'b1;
    @(posedge clk);
    #1;
    px_if.i_valid = 1'b0;
    px_if.i_sof   = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] mag, input logic [3:0] idx, input bit drop4,
                           input bit gaps, input int n_px,
                           output int c00, output int c08, output int c80, output int c77);
    c00 = -1; c08 = -1; c80 = -1; c77 = -1;
    for (int p = 0; p < n_px; p++) begin
      int r, c;
      r = p / W_PX;
      c = p % W_PX;
      if (gaps && p > 0) repeat ($urandom_range(1, 3)) idle();
      if (r == 0 && c == 0)  c00 = cyc;
      if (r == 0 && c == SZ) c08 = cyc;
      if (r == SZ && c == 0) c80 = cyc;
      if (r == SZ - 1 && c == SZ - 1) c77 = cyc;
      drive_px(mag, (drop4 && (c % 4 == 3)) ? 4'd9 : idx, p == 0);
    end
  endtask

  task automatic check_frame(input string tag, input logic [TOT-1:0] ev,
                             input int c00, input int c08, input int c80, input int c77);
    repeat (4) idle();
    chk_int({tag, " ov_count"}, ov_addr.size(), NCELL);
    for (int i = 0; i < ov_addr.size() && i < NCELL; i++) begin
      chk_int($sformatf("%s ov_addr[%0d]", tag, i), ov_addr[i], i);
      chk($sformatf("%s bin[%0d]", tag, i), ov_bin[i], ev);
    end
    chk_int({tag, " fw_count"}, fw_addr.size(), NCELL);
    for (int i = 0; i < fw_addr.size() && i < NCELL; i++)
      chk_int($sformatf("%s fw_addr[%0d]", tag, i), fw_addr[i], i);
    if (fw_cyc.size() > CC) begin
      chk_int({tag, " fw0_lat"}, fw_cyc[0], c00 + 1);
      chk_int({tag, " fw1_lat"}, fw_cyc[1], c08 + 1);
      chk_int({tag, " fw_row1_lat"}, fw_cyc[CC], c80 + 1);
    end
    if (ov_cyc.size() > 0) chk_int({tag, " ov0_lat"}, ov_cyc[0], c77 + 2);
    chk_int({tag, " hold_addr"}, int'(px_if.address), NCELL - 1);
    chk_int({tag, " strobe_low"}, int'(px_if.o_valid), 0);
  endtask

  function automatic logic [TOT-1:0] exp_vec(input int b, input logic [31:0] v);
    logic [TOT-1:0] e;
    e = '0;
    if (b < 9) e[b*BW +: BW] = v;
    return e;
  endfunction

  vec_t tbl[7];
  int   c00, c08, c80, c77;

  initial begin
    px_if.i_mag = '0; px_if.i_bin_idx = '0; px_if.i_sof = 1'b0; px_if.i_valid = 1'b0;
    tbl[0] = '{16'hFFFF, 4'd0, 1'b0, 1'b0, 0, 32'hFFFF_FFFF};
    tbl[1] = '{16'h0001, 4'd3, 1'b0, 1'b0, 3, 32'h0040_0000};
    tbl[2] = '{16'h03FF, 4'd5, 1'b0, 1'b0, 5, 32'hFFC0_0000};
    tbl[3] = '{16'h0401, 4'd1, 1'b0, 1'b0, 1, 32'hFFFF_FFFF};
    tbl[4] = '{16'h0005, 4'd9, 1'b0, 1'b0, 9, 32'h0000_0000};
    tbl[5] = '{16'h0001, 4'd3, 1'b1, 1'b1, 3, 32'h0030_0000};
    tbl[6] = '{16'h0002, 4'd8, 1'b0, 1'b1, 8, 32'h0080_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst o_valid", int'(px_if.o_valid), 0);
    chk_int("rst valid_fw", int'(px_if.valid_fw), 0);
    chk_int("rst address", int'(px_if.address), 0);
    chk_int("rst addr_fw", int'(px_if.addr_fw), 0);
    chk("rst bin", px_if.bin, '0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 20; i++) drive_px(16'd1, 4'd3, 1'b0);
    repeat (3) idle();
    chk_int("pre_sof ov", ov_addr.size(), 0);
    chk_int("pre_sof fw", fw_addr.size(), 0);

    for (int v = 0; v < 7; v++) begin
      clear_logs();
      run_frame(tbl[v].mag, tbl[v].idx, tbl[v].drop4, tbl[v].gaps, NPX, c00, c08, c80, c77);
      check_frame($sformatf("vec%0d", v), exp_vec(tbl[v].exp_bin, tbl[v].exp_val), c00, c08, c80, c77);
    end

    clear_logs();
    for (int i = 0; i < 8; i++) drive_px(16'd1, 4'd3, 1'b0);
    repeat (3) idle();
    chk_int("post_frame ov", ov_addr.size(), 0);
    chk_int("post_frame fw", fw_addr.size(), 0);

    run_frame(16'd7, 4'd2, 1'b0, 1'b0, 5 * W_PX + 20, c00, c08, c80, c77);
    repeat (3) idle();
    chk_int("abort ov", ov_addr.size(), 0);
    clear_logs();
    run_frame(16'd1, 4'd4, 1'b0, 1'b0, NPX, c00, c08, c80, c77);
    check_frame("abort", exp_vec(4, 32'h0040_0000), c00, c08, c80, c77);

    clear_logs();
    run_frame(16'd1, 4'd6, 1'b0, 1'b0, 300, c00, c08, c80, c77);
    chk_int("pre_rst address", int'(px_if.address), CC - 1);
    rst = 1'b0;
    #1;
    chk_int("mid_rst o_valid", int'(px_if.o_valid), 0);
    chk_int("mid_rst valid_fw", int'(px_if.valid_fw), 0);
    chk_int("mid_rst address", int'(px_if.address), 0);
    chk_int("mid_rst addr_fw", int'(px_if.addr_fw), 0);
    chk("mid_rst bin", px_if.bin, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_logs();
    for (int i = 0; i < 10; i++) drive_px(16'd1, 4'd6, 1'b0);
    repeat (3) idle();
    chk_int("after_rst ov", ov_addr.size(), 0);
    chk_int("after_rst fw", fw_addr.size(), 0);
    clear_logs();
    run_frame(16'd1, 4'd3, 1'b0, 1'b0, NPX, c00, c08, c80, c77);
    check_frame("after_rst", exp_vec(3, 32'h0040_0000), c00, c08, c80, c77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
